pipe_datapath: RTL and testbench

Parametrised two-stage register-file/ALU datapath that succeeds the single-cycle register/ALU pair. It accepts one instruction per cycle over a valid/ready handshake, reads two operands from an internal register file, executes in a registered ALU stage, and writes the result back to a destination register. It sits between the instruction sequencer and the result consumer. Immediates arrive with the instruction, so loading a value and operating on it are separate instructions.

---
 rtl/datapath_pkg.sv | 25 ++
 rtl/pipe_datapath_if.sv | 33 +++
 rtl/pipe_datapath_regfile_2r1w.sv | 35 +++
 rtl/pipe_datapath.sv | 149 ++++++++++++++
 tb/tb_pipe_datapath.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the two-stage register-file/ALU datapath:
// opcode encoding, opcode width and default geometry.
package datapath_pkg;

   localparam int OP_W       = 3;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_NREG   = 8;

   typedef enum logic [OP_W-1:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_AND   = 3'd2,
      OP_OR    = 3'd3,
      OP_XOR   = 3'd4,
      OP_SHL   = 3'd5,
      OP_PASSA = 3'd6,
      OP_LDI   = 3'd7
   } alu_op_e;

   // LDI takes its value from the immediate, so its ra/rb never matter.
   function automatic logic op_reads_regs(input alu_op_e op);
      return (op != OP_LDI);
   endfunction

endpackage

// File: rtl/pipe_datapath_if.sv
// Instruction/result bundle between the sequencer (master) and pipe_datapath (slave).
interface pipe_datapath_if #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8
);
   import datapath_pkg::*;

   localparam int AW = $clog2(NREG);

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_op;
   logic [AW-1:0]     in_ra;
   logic [AW-1:0]     in_rb;
   logic [AW-1:0]     in_rd;
   logic              in_wb;
   logic [DATA_W-1:0] in_imm;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_zero;
   logic              out_carry;

   modport master (
      output in_valid, in_op, in_ra, in_rb, in_rd, in_wb, in_imm,
      input  in_ready, out_valid, out_data, out_zero, out_carry
   );

   modport slave (
      input  in_valid, in_op, in_ra, in_rb, in_rd, in_wb, in_imm,
      output in_ready, out_valid, out_data, out_zero, out_carry
   );

endinterface

// File: rtl/pipe_datapath_regfile_2r1w.sv
// NREG x DATA_W register file: two asynchronous read ports, one synchronous
// write port, synchronous active-low clear of every entry.
module regfile_2r1w #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     ra,
   input  logic [AW-1:0]     rb,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] mem_r [NREG];

   // Storage update: clear wins over a write on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem_r[i] <= '0;
         end
      end else if (we) begin
         mem_r[wa] <= wdata;
      end
   end

   assign rdata_a = mem_r[ra];
   assign rdata_b = mem_r[rb];

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage register-file/ALU datapath (read stage R, execute/write-back stage X).
// Optional feature macro: PIPE_DATAPATH_FWD_EN (X-stage result bypass into R; no hazard stall).
module pipe_datapath
   import datapath_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREG   = DEF_NREG
) (
   input  logic             CLK,
   input  logic             RST_N,
   pipe_datapath_if.slave   bus
);

   localparam int AW   = $clog2(NREG);
   localparam int SH_W = $clog2(DATA_W);

   logic              ex_valid_r;
   alu_op_e           ex_op_r;
   logic [AW-1:0]     ex_rd_r;
   logic              ex_wb_r;
   logic [DATA_W-1:0] ex_imm_r;
   logic [DATA_W-1:0] ex_a_r;
   logic [DATA_W-1:0] ex_b_r;

   logic              out_valid_r;
   logic [DATA_W-1:0] out_data_r;
   logic              out_zero_r;
   logic              out_carry_r;

   logic [DATA_W-1:0] rf_a_s;
   logic [DATA_W-1:0] rf_b_s;
   logic [DATA_W-1:0] op_a_s;
   logic [DATA_W-1:0] op_b_s;
   logic [DATA_W-1:0] alu_res_s;
   logic              alu_carry_s;
   logic [DATA_W:0]   sum_s;
   logic              match_a_s;
   logic              match_b_s;
   logic              ready_s;
   logic              accept_s;
   logic              wr_en_s;

   assign wr_en_s = RST_N && ex_valid_r && ex_wb_r;

   regfile_2r1w #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
      .clk     (CLK),
      .rst_n   (RST_N),
      .ra      (bus.in_ra),
      .rb      (bus.in_rb),
      .rdata_a (rf_a_s),
      .rdata_b (rf_b_s),
      .we      (wr_en_s),
      .wa      (ex_rd_r),
      .wdata   (alu_res_s)
   );

   // Hazard detection and operand selection for the instruction offered in R.
   always_comb begin
      match_a_s = ex_valid_r && ex_wb_r && (ex_rd_r == bus.in_ra);
      match_b_s = ex_valid_r && ex_wb_r && (ex_rd_r == bus.in_rb);
`ifdef PIPE_DATAPATH_FWD_EN
      ready_s = RST_N;
      op_a_s  = match_a_s ? alu_res_s : rf_a_s;
      op_b_s  = match_b_s ? alu_res_s : rf_b_s;
`else
      // Hold off one cycle so the pending write lands before the read.
      ready_s = RST_N && !(op_reads_regs(alu_op_e'(bus.in_op)) && (match_a_s || match_b_s));
      op_a_s  = rf_a_s;
      op_b_s  = rf_b_s;
`endif
   end

   assign accept_s     = bus.in_valid && ready_s;
   assign bus.in_ready = ready_s;

   // X-stage ALU; carry is meaningful only for ADD and SUB.
   always_comb begin
      alu_res_s   = '0;
      alu_carry_s = 1'b0;
      sum_s       = '0;
      case (ex_op_r)
         OP_ADD: begin
            sum_s       = {1'b0, ex_a_r} + {1'b0, ex_b_r};
            alu_res_s   = sum_s[DATA_W-1:0];
            alu_carry_s = sum_s[DATA_W];
         end
         OP_SUB: begin
            alu_res_s   = ex_a_r - ex_b_r;
            alu_carry_s = (ex_a_r >= ex_b_r);
         end
         OP_AND:   alu_res_s = ex_a_r & ex_b_r;
         OP_OR:    alu_res_s = ex_a_r | ex_b_r;
         OP_XOR:   alu_res_s = ex_a_r ^ ex_b_r;
         OP_SHL:   alu_res_s = ex_a_r << ex_b_r[SH_W-1:0];
         OP_PASSA: alu_res_s = ex_a_r;
         OP_LDI:   alu_res_s = ex_imm_r;
         default: begin
            alu_res_s   = '0;
            alu_carry_s = 1'b0;
         end
      endcase
   end

   // R -> X pipeline register; reset drops any in-flight instruction.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         ex_valid_r <= 1'b0;
         ex_op_r    <= OP_ADD;
         ex_rd_r    <= '0;
         ex_wb_r    <= 1'b0;
         ex_imm_r   <= '0;
         ex_a_r     <= '0;
         ex_b_r     <= '0;
      end else begin
         ex_valid_r <= accept_s;
         if (accept_s) begin
            ex_op_r  <= alu_op_e'(bus.in_op);
            ex_rd_r  <= bus.in_rd;
            ex_wb_r  <= bus.in_wb;
            ex_imm_r <= bus.in_imm;
            ex_a_r   <= op_a_s;
            ex_b_r   <= op_b_s;
         end
      end
   end

   // Result registers; data and flags hold their last value between pulses.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_zero_r  <= 1'b0;
         out_carry_r <= 1'b0;
      end else begin
         out_valid_r <= ex_valid_r;
         if (ex_valid_r) begin
            out_data_r  <= alu_res_s;
            out_zero_r  <= (alu_res_s == '0);
            out_carry_r <= alu_carry_s;
         end
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_zero  = out_zero_r;
   assign bus.out_carry = out_carry_r;

endmodule

// File: tb/tb_pipe_datapath.sv
// Self-checking bench for pipe_datapath: directed steps, random traffic against a
// sequential architectural model, and a DATA_W=32/NREG=16 instance. Honors PIPE_DATAPATH_FWD_EN.
module tb_pipe_datapath;

   localparam int DW = 16;
   localparam int NR = 8;

`ifdef PIPE_DATAPATH_FWD_EN
   localparam int EXP_STALL = 0;
`else
   localparam int EXP_STALL = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   pipe_datapath_if #(.DATA_W(DW), .NREG(NR)) bus ();
   pipe_datapath_if #(.DATA_W(32), .NREG(16)) bus32 ();

   pipe_datapath #(.DATA_W(DW), .NREG(NR)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   pipe_datapath #(.DATA_W(32), .NREG(16)) dut32 (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus32)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Architectural model: registers updated in program order at acceptance.
   int unsigned mrf [NR];
   bit          r_v, r_wb, r_c, x_v, x_c;
   int          r_rd;
   longint unsigned r_res, x_res;
   int          dut_low;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void ref_exec(input int op, input longint unsigned a, input longint unsigned b,
                                    input longint unsigned imm, input int w,
                                    output longint unsigned res, output bit c);
      longint unsigned m;
      m = 64'd1 << w;
      c = 1'b0;
      case (op)
         0: begin res = a + b; c = (res >= m); end
         1: begin res = a + m - b; c = (a >= b); end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: res = a << (b % w);
         6: res = a;
         7: res = imm;
         default: res = 0;
      endcase
      res = res % m;
   endfunction

   function automatic bit exp_ready(input bit rn, input int op, input int ra, input int rb);
`ifdef PIPE_DATAPATH_FWD_EN
      return rn;
`else
      return rn && !(r_v && r_wb && op != 7 && (r_rd == ra || r_rd == rb));
`endif
   endfunction

   // One clock: drive, check in_ready, clock, advance model, check outputs.
   task automatic step(input bit v, input int op, input int ra, input int rb, input int rd,
                       input bit wb, input logic [63:0] imm, output bit acc);
      bit er;
      bit c;
      longint unsigned res;
      bus.in_valid = v;
      bus.in_op    = op[2:0];
      bus.in_ra    = ra[2:0];
      bus.in_rb    = rb[2:0];
      bus.in_rd    = rd[2:0];
      bus.in_wb    = wb;
      bus.in_imm   = imm[DW-1:0];
      #1;
      er = exp_ready(rst_n, op, ra, rb);
      chk("in_ready", bus.in_ready, er);
      if (bus.in_ready === 1'b0) dut_low++;
      acc = v && er;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         foreach (mrf[i]) mrf[i] = 0;
         r_v = 1'b0;
         x_v = 1'b0;
         chk("rst_out_valid", bus.out_valid, 1'b0);
         chk("rst_out_data", bus.out_data, 0);
         chk("rst_out_zero", bus.out_zero, 1'b0);
         chk("rst_out_carry", bus.out_carry, 1'b0);
      end else begin
         x_v   = r_v;
         x_res = r_res;
         x_c   = r_c;
         r_v   = acc;
         if (acc) begin
            ref_exec(op, mrf[ra], mrf[rb], imm[DW-1:0], DW, res, c);
            r_res = res;
            r_c   = c;
            r_wb  = wb;
            r_rd  = rd;
            if (wb) mrf[rd] = int'(res);
         end
         chk("out_valid", bus.out_valid, x_v);
         if (x_v) begin
            chk("out_data", bus.out_data, x_res);
            chk("out_zero", bus.out_zero, x_res == 0);
            chk("out_carry", bus.out_carry, x_c);
         end
      end
   endtask

   task automatic idle();
      bit acc;
      step(1'b0, 7, 0, 0, 0, 1'b0, 64'd0, acc);
   endtask

   // Offer one instruction until accepted; dut_low counts cycles in_ready was low.
   task automatic issue(input int op, input int ra, input int rb, input int rd,
                        input bit wb, input logic [63:0] imm);
      bit acc;
      acc = 1'b0;
      dut_low = 0;
      for (int t = 0; t < 3; t++) begin
         step(1'b1, op, ra, rb, rd, wb, imm, acc);
         if (acc) break;
      end
      chk("issue_accepted", acc, 1'b1);
   endtask

   task automatic expect_out(input string tag, input logic [63:0] data, input bit z, input bit c);
      chk({tag, "_valid"}, bus.out_valid, 1'b1);
      chk({tag, "_data"}, bus.out_data, data);
      chk({tag, "_zero"}, bus.out_zero, z);
      chk({tag, "_carry"}, bus.out_carry, c);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int op, ra, rb, rd;
      bit v, wb;
      logic [63:0] imm;

      foreach (mrf[i]) mrf[i] = 0;
      r_v = 1'b0; x_v = 1'b0; r_wb = 1'b0; r_rd = 0; r_c = 1'b0; x_c = 1'b0;
      r_res = 0; x_res = 0; dut_low = 0;
      bus32.in_valid = 1'b0; bus32.in_op = 3'd7; bus32.in_ra = 4'd0; bus32.in_rb = 4'd0;
      bus32.in_rd = 4'd0; bus32.in_wb = 1'b0; bus32.in_imm = 32'd0;

      rst_n = 1'b0;
      idle();
      idle();
      rst_n = 1'b1;

      // Reset then idle, PASSA r3 -> 0
      idle();
      chk("idle_out_data", bus.out_data, 0);
      issue(6, 3, 0, 0, 1'b0, 64'd0);
      idle();
      expect_out("passa_reset", 64'h0, 1'b1, 1'b0);

      // ADD wraps to zero with carry
      issue(7, 0, 0, 1, 1'b1, 64'hFFFF);
      issue(7, 0, 0, 2, 1'b1, 64'h0001);
      idle();
      issue(0, 1, 2, 3, 1'b1, 64'd0);
      idle();
      expect_out("add_wrap", 64'h0, 1'b1, 1'b1);
      issue(6, 3, 0, 0, 1'b0, 64'd0);
      idle();
      expect_out("passa_r3", 64'h0, 1'b1, 1'b0);

      // Back-to-back dependent SUB
      issue(7, 0, 0, 1, 1'b1, 64'd5);
      issue(1, 1, 1, 4, 1'b1, 64'd0);
      chk("b2b_stall_cycles", dut_low, EXP_STALL);
      idle();
      expect_out("b2b_sub", 64'h0, 1'b1, 1'b1);

      // SUB with borrow
      issue(7, 0, 0, 5, 1'b1, 64'd3);
      issue(7, 0, 0, 6, 1'b1, 64'd7);
      idle();
      issue(1, 5, 6, 7, 1'b0, 64'd0);
      idle();
      expect_out("sub_borrow", 64'hFFFC, 1'b0, 1'b0);

      // SHL uses only the low shift bits
      issue(7, 0, 0, 1, 1'b1, 64'h0001);
      issue(7, 0, 0, 2, 1'b1, 64'h0013);
      idle();
      issue(5, 1, 2, 3, 1'b1, 64'd0);
      idle();
      expect_out("shl_mod", 64'h0008, 1'b0, 1'b0);

      // Reset with ADD wb=1 in EX
      issue(0, 1, 2, 6, 1'b1, 64'd0);
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      idle();
      chk("post_rst_out_valid", bus.out_valid, 1'b0);
      issue(6, 6, 0, 0, 1'b0, 64'd0);
      idle();
      expect_out("rst_target", 64'h0, 1'b1, 1'b0);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         v   = ($urandom_range(0, 3) != 0);
         op  = $urandom_range(0, 7);
         ra  = $urandom_range(0, NR - 1);
         rb  = $urandom_range(0, NR - 1);
         rd  = $urandom_range(0, NR - 1);
         wb  = ($urandom_range(0, 3) != 0);
         imm = 64'($urandom_range(0, 65535));
         if ($urandom_range(0, 7) == 0) imm = 64'hFFFF;
         step(v, op, ra, rb, rd, wb, imm, acc);
      end
      idle();
      idle();
      bus.in_valid = 1'b0;

      // DATA_W=32, NREG=16 instance
      bus32.in_valid = 1'b1; bus32.in_op = 3'd7; bus32.in_rd = 4'd15;
      bus32.in_wb = 1'b1; bus32.in_imm = 32'h8000_0000;
      #1;
      chk("w32_ready_ldi", bus32.in_ready, 1'b1);
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("w32_ldi_valid", bus32.out_valid, 1'b1);
      chk("w32_ldi_data", bus32.out_data, 64'h8000_0000);
      bus32.in_valid = 1'b1; bus32.in_op = 3'd0; bus32.in_ra = 4'd15; bus32.in_rb = 4'd15;
      bus32.in_rd = 4'd15; bus32.in_wb = 1'b1;
      #1;
      chk("w32_ready_add", bus32.in_ready, 1'b1);
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("w32_add_valid", bus32.out_valid, 1'b1);
      chk("w32_add_data", bus32.out_data, 64'h0);
      chk("w32_add_carry", bus32.out_carry, 1'b1);
      chk("w32_add_zero", bus32.out_zero, 1'b1);
      bus32.in_valid = 1'b1; bus32.in_op = 3'd6; bus32.in_ra = 4'd15; bus32.in_wb = 1'b0;
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("w32_passa_valid", bus32.out_valid, 1'b1);
      chk("w32_passa_data", bus32.out_data, 64'h0);
      chk("w32_passa_carry", bus32.out_carry, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
